// File: rtl/main_memory_ctrl_pkg.sv
// Shared definitions for the backing-store memory controller, its cache and CPU.
// Optional MEM_WRITE_PROTECT_EN (used by main_memory_ctrl) guards the instruction region.
package main_memory_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } mem_state_e;

  localparam logic [31:0] MEM_INSTR_BASE  = 32'h0000_0000;
  localparam logic [31:0] MEM_INSTR_LIMIT = 32'h0000_01FC;
  localparam logic [31:0] MEM_DATA_BASE   = 32'h0000_0200;

  // Word accesses only: the low two byte-offset bits never reach the array.
  localparam int BYTE_OFS_W = 2;
  localparam int WORD_ADDR_W = 32 - BYTE_OFS_W;

endpackage

// File: rtl/main_memory_ctrl_mem_word_array.sv
// Single-port 32-bit word RAM with registered read data and an address range flag.
// Contents are not reset; out-of-range writes are dropped and reads return zero.
module mem_word_array
  import main_memory_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [WORD_ADDR_W-1:0] word_addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   oor
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]      mem_r [0:DEPTH_WORDS-1];
  logic [31:0]      rdata_r;
  logic [IDX_W-1:0] idx_s;
  logic             oor_s;

  assign idx_s = word_addr[IDX_W-1:0];
  assign oor_s = (word_addr >= WORD_ADDR_W'(DEPTH_WORDS));

  // Array write port; the range check keeps aliased indices from being touched.
  always_ff @(posedge CLK) begin
    if (wr_en && !oor_s) begin
      mem_r[idx_s] <= wdata;
    end
  end

  // Read data register holds its value across writes and idle cycles.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rdata_r <= 32'h0;
    end else if (rd_en) begin
      rdata_r <= oor_s ? 32'h0 : mem_r[idx_s];
    end
  end

  assign rdata = rdata_r;
  assign oor   = oor_s;

endmodule

// File: rtl/main_memory_ctrl.sv
// Backing-store controller: latches one cache request, waits LATENCY cycles, accesses
// the word array, then pulses mem_ready. Define MEM_WRITE_PROTECT_EN to block instruction-region writes.
module main_memory_ctrl
  import main_memory_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [31:0] mem_req_addr,
  input  logic        mem_req_rw,
  input  logic        mem_req_valid,
  input  logic [31:0] mem_data_write,
  output logic [31:0] mem_data_read,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_err
);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  mem_state_e             state_r;
  mem_state_e             next_state_s;
  logic [3:0]             cnt_r;
  logic [WORD_ADDR_W-1:0] addr_r;
  logic                   rw_r;
  logic [31:0]            wdata_r;
  logic                   accept_s;
  logic                   access_s;
  logic                   oor_s;
  logic                   prot_s;
  logic                   ready_r;
  logic                   busy_r;
  logic                   err_r;
  logic                   unused_addr_lsb_s;

  assign unused_addr_lsb_s = ^mem_req_addr[BYTE_OFS_W-1:0];
  assign accept_s = (state_r == ST_IDLE) && mem_req_valid;

  // State register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state; the access strobe fires on the last BUSY cycle.
  always_comb begin
    next_state_s = state_r;
    access_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_req_valid) next_state_s = ST_BUSY;
        else               next_state_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (cnt_r == 4'd0) begin
          next_state_s = ST_RESP;
          access_s     = 1'b1;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      ST_RESP: next_state_s = ST_GAP;
      ST_GAP:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Latency counter: loaded on acceptance, counts down to zero while BUSY.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt_r <= 4'd0;
    end else if (accept_s) begin
      cnt_r <= LAT_LOAD;
    end else if ((state_r == ST_BUSY) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Request latch; inputs are ignored outside IDLE.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      addr_r  <= '0;
      rw_r    <= 1'b0;
      wdata_r <= 32'h0;
    end else if (accept_s) begin
      addr_r  <= mem_req_addr[31:BYTE_OFS_W];
      rw_r    <= mem_req_rw;
      wdata_r <= mem_data_write;
    end
  end

`ifdef MEM_WRITE_PROTECT_EN
  assign prot_s = rw_r && ({addr_r, 2'b00} <= MEM_INSTR_LIMIT);
`else
  assign prot_s = 1'b0;
`endif

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .rd_en     (access_s && !rw_r),
    .wr_en     (access_s && rw_r && !prot_s),
    .word_addr (addr_r),
    .wdata     (wdata_r),
    .rdata     (mem_data_read),
    .oor       (oor_s)
  );

  // Handshake and sticky error flags, registered from the next state.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ready_r <= (next_state_s == ST_RESP);
      busy_r  <= (next_state_s != ST_IDLE);
      err_r   <= err_r | (access_s & (oor_s | prot_s));
    end
  end

  assign mem_ready = ready_r;
  assign mem_busy  = busy_r;
  assign mem_err   = err_r;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: directed scenarios plus randomized requests
// checked against a word-array reference model.
module tb_main_memory_ctrl;

  localparam int DEPTH = 1024;
  localparam int LAT   = 4;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [31:0] mem_req_addr = 32'h0;
  logic        mem_req_rw = 1'b0;
  logic        mem_req_valid = 1'b0;
  logic [31:0] mem_data_write = 32'h0;
  logic [31:0] mem_data_read;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_err;

  main_memory_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .CLK            (CLK),
    .RESETn         (RESETn),
    .mem_req_addr   (mem_req_addr),
    .mem_req_rw     (mem_req_rw),
    .mem_req_valid  (mem_req_valid),
    .mem_data_write (mem_data_write),
    .mem_data_read  (mem_data_read),
    .mem_ready      (mem_ready),
    .mem_busy       (mem_busy),
    .mem_err        (mem_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] mdl [0:DEPTH-1];
  logic [31:0] m_rd = 32'h0;
  logic        m_err = 1'b0;
  int          last_ready_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one completed request.
  task automatic model_access(input logic [31:0] a, input logic rw, input logic [31:0] d);
    int  idx;
    bit  oor;
    bit  prot;
    idx  = int'(a >> 2);
    oor  = (a[31:2] >= 30'(DEPTH));
    prot = 1'b0;
`ifdef MEM_WRITE_PROTECT_EN
    prot = rw && ({a[31:2], 2'b00} <= 32'h1FC);
`endif
    if (rw) begin
      if (!oor && !prot) mdl[idx] = d;
    end else begin
      m_rd = oor ? 32'h0 : mdl[idx];
    end
    if (oor || prot) m_err = 1'b1;
  endtask

  // One cache-style transaction; optionally scrambles inputs or drops valid while BUSY.
  task automatic do_req(input logic [31:0] a, input logic rw, input logic [31:0] d,
                        input bit scramble, input bit drop);
    int n;
    bit seen;
    @(negedge CLK);
    mem_req_addr = a; mem_req_rw = rw; mem_data_write = d; mem_req_valid = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge CLK); #1; n++;
      if (n == 1) begin
        check("busy_after_accept", {31'h0, mem_busy}, 32'h1);
        if (scramble) begin
          mem_req_addr = $urandom; mem_req_rw = ~rw; mem_data_write = $urandom;
        end
        if (drop) mem_req_valid = 1'b0;
      end
      if (mem_ready) seen = 1'b1;
    end
    check("ready_seen", {31'h0, seen}, 32'h1);
    check("ready_latency", n, LAT + 1);
    last_ready_cyc = cyc;
    model_access(a, rw, d);
    check("rdata", mem_data_read, m_rd);
    check("err", {31'h0, mem_err}, {31'h0, m_err});
    check("busy_resp", {31'h0, mem_busy}, 32'h1);
    @(posedge CLK); #1;
    check("ready_pulse_width", {31'h0, mem_ready}, 32'h0);
    check("busy_gap", {31'h0, mem_busy}, 32'h1);
    mem_req_valid = 1'b0;
    @(posedge CLK); #1;
    check("busy_idle", {31'h0, mem_busy}, 32'h0);
    check("no_dup_ready", {31'h0, mem_ready}, 32'h0);
  endtask

  initial begin
    int t1;
    logic [31:0] a;
    logic [31:0] d;
    logic        rw;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready", {31'h0, mem_ready}, 32'h0);
    check("rst_busy", {31'h0, mem_busy}, 32'h0);
    check("rst_err", {31'h0, mem_err}, 32'h0);
    check("rst_rdata", mem_data_read, 32'h0);
    @(negedge CLK); RESETn = 1'b1;

    do_req(32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
    do_req(32'h204, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    t1 = last_ready_cyc;
    do_req(32'h204, 1'b0, 32'h0, 1'b0, 1'b0);
    check("throughput", last_ready_cyc - t1, LAT + 3);
    do_req(32'h208, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1);
    do_req(32'h20A, 1'b0, 32'h0, 1'b1, 1'b0);

    do_req(32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);
    do_req(32'h204, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset in the middle of a write must abandon it.
    @(negedge CLK);
    mem_req_addr = 32'h300; mem_req_rw = 1'b1; mem_data_write = 32'h55; mem_req_valid = 1'b1;
    @(posedge CLK); #1;
    mem_req_valid = 1'b0;
    @(posedge CLK); #1;
    RESETn = 1'b0;
    #1;
    check("midrst_ready", {31'h0, mem_ready}, 32'h0);
    check("midrst_busy", {31'h0, mem_busy}, 32'h0);
    check("midrst_err", {31'h0, mem_err}, 32'h0);
    m_err = 1'b0; m_rd = 32'h0;
    repeat (LAT + 2) begin
      @(posedge CLK); #1;
      check("rst_held_ready", {31'h0, mem_ready}, 32'h0);
    end
    @(negedge CLK); RESETn = 1'b1;
    do_req(32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
    do_req(32'h204, 1'b0, 32'h0, 1'b0, 1'b0);

`ifdef MEM_WRITE_PROTECT_EN
    do_req(32'h1FC, 1'b1, 32'h1234, 1'b0, 1'b0);
    do_req(32'h1FC, 1'b0, 32'h0, 1'b0, 1'b0);
`endif

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4;
      else a = 32'h200 + 32'($urandom_range(0, 31)) * 32'd4;
      a  = a | 32'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      d  = $urandom;
      do_req(a, rw, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
